ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, meaning RAM depth in words.
REQ-002 SHALL have parameter MEM_WIDTH, default 8, meaning RAM word width in bits.
REQ-003 SHALL define AW = $clog2(MEM_SIZE) as the address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports {a,b}_valid, input, 1 bit each: the requester presents an access.
REQ-007 SHALL have ports {a,b}_ready, output, 1 bit each: the access is accepted this cycle.
REQ-008 SHALL have ports {a,b}_wr, input, 1 bit each: 1 = write, 0 = read.
REQ-009 SHALL have ports {a,b}_addr, input, AW bits each: the word address.
REQ-010 SHALL have ports {a,b}_wdata, input, MEM_WIDTH bits each: the write data.
REQ-011 SHALL have ports {a,b}_rsp_valid, output, 1 bit each: a response for that requester is present.
REQ-012 SHALL have ports {a,b}_rdata, output, MEM_WIDTH bits each: the response data.
REQ-013 SHALL have port fill_start, input, 1 bit: request a whole-RAM fill.
REQ-014 SHALL have port fill_data, input, MEM_WIDTH bits: the fill value.
REQ-015 SHALL have port fill_busy, output, 1 bit: a fill is in progress.
REQ-016 SHALL have port fill_done, output, 1 bit: one-cycle pulse when a fill completes.
REQ-017 SHALL have ports mem_wr (output, 1), mem_addr (output, AW), mem_wdata (output, MEM_WIDTH) and mem_rdata (input, MEM_WIDTH), which drive a single-port synchronous RAM with 1-cycle read latency that returns wdata on a write.

Function
REQ-018 SHALL use FSM states IDLE and FILL; state resets to IDLE.
REQ-019 In IDLE, SHALL grant at most one requester per cycle; grant = valid & ready.
REQ-020 Arbitration SHALL be round-robin:
- if only one requester is valid, that one wins;
- if both are valid, the requester not granted last wins;
- last_grant resets to B, so A wins the first tie.
REQ-021 The ready outputs SHALL be combinational, asserted only for the winner in IDLE, and 0 in FILL and while reset is high.
REQ-022 On a grant, mem_addr, mem_wdata and mem_wr (= winner's wr) SHALL be driven combinationally from the winner in the same cycle.
REQ-023 With no grant in IDLE, SHALL drive mem_wr = 0 and mem_addr = 0.
REQ-024 Latency SHALL be exactly 1 cycle: after a grant, the winner's rsp_valid is registered high for one cycle and the winner's rdata = mem_rdata.
REQ-025 A response SHALL be produced for both reads and writes; a write response returns the written data.
REQ-026 rsp_valid SHALL never be high for both requesters in the same cycle.
REQ-027 {a,b}_rdata SHALL be don't-care when the matching rsp_valid is 0.
REQ-028 fill_start in IDLE SHALL:
- register fill_data;
- clear the address counter to 0;
- move to FILL on the next edge.
REQ-029 A grant in the same cycle as fill_start SHALL still complete, and its response SHALL appear in the first FILL cycle.
REQ-030 In FILL, SHALL drive mem_wr = 1, mem_addr = counter and mem_wdata = the registered fill value, and increment the counter each cycle.
REQ-031 The write at counter = MEM_SIZE-1 SHALL be the last; on the next edge the block returns to IDLE and fill_done pulses for exactly 1 cycle.
REQ-032 A fill SHALL take exactly MEM_SIZE cycles.
REQ-033 fill_busy SHALL be 1 exactly while the state is FILL.
REQ-034 fill_start SHALL be ignored while in FILL.
REQ-035 The counter SHALL be AW+1 bits wide, so that non-power-of-2 MEM_SIZE terminates correctly.

Reset
REQ-036 Reset SHALL force:
- state IDLE, counter 0, last_grant B;
- {a,b}_rsp_valid = 0, fill_busy = 0, fill_done = 0, mem_wr = 0.
REQ-037 Reset asserted mid-fill SHALL abort the fill without a fill_done pulse; RAM contents are then unspecified.
REQ-038 Reset SHALL drop any response still pending.

Structure
REQ-039 Package ram_arb_pkg SHALL hold the FSM state encoding (IDLE, FILL) and the requester-id constants (REQ_A, REQ_B).
REQ-040 The round-robin grant logic, including the last_grant register, SHALL be a sub-module rr_arb2.
REQ-041 Target size SHALL be 120-400 lines of RTL.

Verification
REQ-042 Single read: preload mem[0x010] = 0x5A; a_valid with a_wr = 0, a_addr = 0x010 -> a_ready the same cycle; next cycle a_rsp_valid = 1 and a_rdata = 0x5A; b_rsp_valid = 0.
REQ-043 Contention: a_valid and b_valid held high for 4 cycles after reset -> grants A, B, A, B; each response arrives 1 cycle after its grant.
REQ-044 Write then read: B writes 0x33 to 0x1FF -> b_rdata = 0x33 on the next cycle; A then reads 0x1FF -> 0x33.
REQ-045 Fill: fill_start with fill_data = 0xC3 -> fill_busy high for 512 cycles, both ready outputs 0, fill_done pulses once; reads at 0x000 and 0x1FF return 0xC3.
REQ-046 Reset mid-fill: reset at fill cycle 100 -> fill_busy = 0 next cycle, no fill_done; a later access is granted normally.
REQ-047 Simultaneous events: a grant in the same cycle as fill_start -> its response appears in the first FILL cycle; fill_start during FILL -> no restart, fill still ends at cycle 512.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the dual-requester RAM arbiter.
package ram_arb_pkg;

    // Top-level control state: normal arbitration or whole-RAM fill
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Requester identities, used for the round-robin history bit
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted most recently.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic a_valid,
    input  logic b_valid,
    output logic grant_a,
    output logic grant_b
);

    logic last_grant;

    // Winner selection from current requests and history
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            grant_a = a_valid & (~b_valid | (last_grant == REQ_B));
            grant_b = b_valid & (~a_valid | (last_grant == REQ_A));
        end
    end

    // History register; B counts as last so A wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_B;
        end else if (grant_a) begin
            last_grant <= REQ_A;
        end else if (grant_b) begin
            last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters, with a
// background-free fill mode that writes one value to every word.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int unsigned MEM_SIZE  = 512,
    parameter  int unsigned MEM_WIDTH = 8,
    localparam int unsigned AW        = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 a_wr,
    input  logic [AW-1:0]        a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_rsp_valid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic                 b_wr,
    input  logic [AW-1:0]        b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_rsp_valid,
    output logic [MEM_WIDTH-1:0] b_rdata,
    input  logic                 fill_start,
    input  logic [MEM_WIDTH-1:0] fill_data,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 mem_wr,
    output logic [AW-1:0]        mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wdata,
    input  logic [MEM_WIDTH-1:0] mem_rdata
);

    // One extra bit so the terminal compare works for any depth
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(MEM_SIZE - 1);

    state_t                 state;
    logic [CW-1:0]          counter;
    logic [MEM_WIDTH-1:0]   fill_value;
    logic                   arb_enable;
    logic                   grant_a;
    logic                   grant_b;

    assign arb_enable = (state == IDLE) & ~reset;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .enable  (arb_enable),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign fill_busy = (state == FILL);

    // RAM data appears one cycle after the grant, aligned with rsp_valid
    assign a_rdata = mem_rdata;
    assign b_rdata = mem_rdata;

    // RAM port steering: fill engine, granted requester, or parked
    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (state == FILL) begin
                mem_wr    = 1'b1;
                mem_addr  = counter[AW-1:0];
                mem_wdata = fill_value;
            end else if (grant_a) begin
                mem_wr    = a_wr;
                mem_addr  = a_addr;
                mem_wdata = a_wdata;
            end else if (grant_b) begin
                mem_wr    = b_wr;
                mem_addr  = b_addr;
                mem_wdata = b_wdata;
            end
        end
    end

    // Control FSM, fill counter and registered response/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            fill_value  <= '0;
            fill_done   <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
        end else begin
            a_rsp_valid <= grant_a;
            b_rsp_valid <= grant_b;
            fill_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        fill_value <= fill_data;
                        counter    <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (counter == LAST_ADDR) begin
                        counter   <= '0;
                        fill_done <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, a per-cycle reference model and
// directed scenarios with literal expectations.
module tb_ram_arbiter;

    localparam int unsigned MEM_SIZE = 512;
    localparam int unsigned W        = 8;
    localparam int unsigned AW       = 9;

    logic          clk;
    logic          reset;
    logic          a_valid, a_ready, a_wr, a_rsp_valid;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_wdata, a_rdata;
    logic          b_valid, b_ready, b_wr, b_rsp_valid;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_wdata, b_rdata;
    logic          fill_start, fill_busy, fill_done;
    logic [W-1:0]  fill_data;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.MEM_SIZE(MEM_SIZE), .MEM_WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_wr(a_wr), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
        .fill_start(fill_start), .fill_data(fill_data),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM, 1-cycle read, write returns wdata
    logic [W-1:0] ram [MEM_SIZE];
    logic [W-1:0] ram_q;
    bit           ram_init = 1'b0;
    assign mem_rdata = ram_q;

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < MEM_SIZE; i++) ram[i] <= '0;
            ram[16]  <= 8'h5A;
            ram_init <= 1'b1;
            ram_q    <= '0;
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
            ram_q         <= mem_wdata;
        end else begin
            ram_q <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit           started = 1'b0;
    always @(posedge clk) started <= 1'b1;

    bit           m_init = 1'b0;
    logic [W-1:0] m_mem   [MEM_SIZE];
    bit           m_known [MEM_SIZE];
    bit           m_busy = 0, m_done = 0, m_last_b = 1;
    bit           m_rsp_a = 0, m_rsp_b = 0, m_rsp_known = 0;
    logic [W-1:0] m_rdata = '0, m_fill_val = '0;
    int           m_cnt = 0;

    // Compare DUT against the model mid-cycle, then advance the model
    always @(negedge clk) begin
        bit           win_a, win_b, wr;
        logic [AW-1:0] addr;
        logic [W-1:0]  wd;
        if (!m_init) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                m_mem[i]   = '0;
                m_known[i] = 1'b1;
            end
            m_mem[16] = 8'h5A;
            m_init    = 1'b1;
        end
        if (started) begin
            chk("fill_busy", 32'(fill_busy), 32'(m_busy));
            chk("fill_done", 32'(fill_done), 32'(m_done));
            chk("a_rsp_valid", 32'(a_rsp_valid), 32'(m_rsp_a));
            chk("b_rsp_valid", 32'(b_rsp_valid), 32'(m_rsp_b));
            chk("rsp_exclusive", 32'(a_rsp_valid & b_rsp_valid), 32'(0));
            if (m_rsp_a && m_rsp_known) chk("a_rdata", 32'(a_rdata), 32'(m_rdata));
            if (m_rsp_b && m_rsp_known) chk("b_rdata", 32'(b_rdata), 32'(m_rdata));

            if (reset) begin
                chk("rst_a_ready", 32'(a_ready), 32'(0));
                chk("rst_b_ready", 32'(b_ready), 32'(0));
                chk("rst_mem_wr", 32'(mem_wr), 32'(0));
                if (m_busy)
                    for (int i = 0; i < MEM_SIZE; i++) m_known[i] = 1'b0;
                m_busy = 0; m_done = 0; m_last_b = 1; m_cnt = 0;
                m_rsp_a = 0; m_rsp_b = 0;
            end else if (m_busy) begin
                chk("fill_a_ready", 32'(a_ready), 32'(0));
                chk("fill_b_ready", 32'(b_ready), 32'(0));
                chk("fill_mem_wr", 32'(mem_wr), 32'(1));
                chk("fill_mem_addr", 32'(mem_addr), 32'(m_cnt));
                chk("fill_mem_wdata", 32'(mem_wdata), 32'(m_fill_val));
                m_rsp_a = 0; m_rsp_b = 0; m_done = 0;
                m_cnt++;
                if (m_cnt == MEM_SIZE) begin
                    m_busy = 0; m_done = 1; m_cnt = 0;
                    for (int i = 0; i < MEM_SIZE; i++) begin
                        m_mem[i]   = m_fill_val;
                        m_known[i] = 1'b1;
                    end
                end
            end else begin
                win_a = a_valid && (!b_valid || m_last_b);
                win_b = b_valid && !win_a;
                chk("a_ready", 32'(a_ready), 32'(win_a));
                chk("b_ready", 32'(b_ready), 32'(win_b));
                wr   = win_a ? a_wr : b_wr;
                addr = win_a ? a_addr : b_addr;
                wd   = win_a ? a_wdata : b_wdata;
                if (win_a || win_b) begin
                    chk("mem_wr", 32'(mem_wr), 32'(wr));
                    chk("mem_addr", 32'(mem_addr), 32'(addr));
                    if (wr) begin
                        chk("mem_wdata", 32'(mem_wdata), 32'(wd));
                        m_mem[addr]   = wd;
                        m_known[addr] = 1'b1;
                        m_rdata       = wd;
                        m_rsp_known   = 1'b1;
                    end else begin
                        m_rdata     = m_mem[addr];
                        m_rsp_known = m_known[addr];
                    end
                    m_last_b = win_b;
                end else begin
                    chk("idle_mem_wr", 32'(mem_wr), 32'(0));
                    chk("idle_mem_addr", 32'(mem_addr), 32'(0));
                end
                m_rsp_a = win_a; m_rsp_b = win_b; m_done = 0;
                if (fill_start) begin
                    m_busy = 1; m_cnt = 0; m_fill_val = fill_data;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit use_b, input bit wr, input logic [AW-1:0] addr,
                          input logic [W-1:0] wd, output logic gnt, output logic rv,
                          output logic [W-1:0] rd);
        if (use_b) begin
            b_valid = 1; b_wr = wr; b_addr = addr; b_wdata = wd;
        end else begin
            a_valid = 1; a_wr = wr; a_addr = addr; a_wdata = wd;
        end
        #2;
        gnt = use_b ? b_ready : a_ready;
        step();
        a_valid = 0; b_valid = 0;
        #2;
        rv = use_b ? b_rsp_valid : a_rsp_valid;
        rd = use_b ? b_rdata : a_rdata;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic          gnt, rv;
        logic [W-1:0]  rd;
        logic [3:0]    ga, gb, ra, rb;
        int            busy_n, done_n, rdy_n, post;

        reset = 1; a_valid = 0; b_valid = 0; a_wr = 0; b_wr = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        fill_start = 0; fill_data = '0;
        #1;
        step(); step();
        reset = 0;
        #2;
        chk("reset_fill_busy", 32'(fill_busy), 32'(0));
        chk("reset_fill_done", 32'(fill_done), 32'(0));
        chk("reset_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'(0));
        chk("reset_mem_wr", 32'(mem_wr), 32'(0));
        step();

        // Contention: A then B alternate starting with A
        ga = '0; gb = '0; ra = '0; rb = '0;
        a_wr = 0; b_wr = 0; a_addr = 9'h010; b_addr = 9'h020;
        for (int i = 0; i < 5; i++) begin
            a_valid = (i < 4); b_valid = (i < 4);
            #2;
            if (i < 4) begin ga = {ga[2:0], a_ready}; gb = {gb[2:0], b_ready}; end
            if (i > 0) begin ra = {ra[2:0], a_rsp_valid}; rb = {rb[2:0], b_rsp_valid}; end
            step();
        end
        chk("contend_grant_a", 32'(ga), 32'(4'b1010));
        chk("contend_grant_b", 32'(gb), 32'(4'b0101));
        chk("contend_rsp_a", 32'(ra), 32'(4'b1010));
        chk("contend_rsp_b", 32'(rb), 32'(4'b0101));

        // Single read of preloaded word
        access(0, 0, 9'h010, 8'h00, gnt, rv, rd);
        chk("read_grant", 32'(gnt), 32'(1));
        chk("read_rsp", 32'(rv), 32'(1));
        chk("read_data", 32'(rd), 32'(8'h5A));

        // Write then read at the top address
        access(1, 1, 9'h1FF, 8'h33, gnt, rv, rd);
        chk("wr_grant", 32'(gnt), 32'(1));
        chk("wr_rsp_data", 32'(rd), 32'(8'h33));
        access(0, 0, 9'h1FF, 8'h00, gnt, rv, rd);
        chk("rd_back_data", 32'(rd), 32'(8'h33));

        // Fill started in the same cycle as a grant
        a_valid = 1; a_wr = 0; a_addr = 9'h010; fill_start = 1; fill_data = 8'hC3;
        #2;
        chk("fill_same_cycle_grant", 32'(a_ready), 32'(1));
        step();
        a_valid = 0; fill_start = 0;
        #2;
        chk("fill_first_busy", 32'(fill_busy), 32'(1));
        chk("fill_first_rsp", 32'(a_rsp_valid), 32'(1));
        chk("fill_first_rdata", 32'(a_rdata), 32'(8'h5A));
        step();
        busy_n = 1; done_n = 0; rdy_n = 0; post = 0;
        for (int k = 0; k < 600 && post < 3; k++) begin
            a_valid = (k >= 100 && k < 110);
            b_valid = (k >= 100 && k < 110);
            fill_start = (k == 200);
            fill_data  = 8'h0F;
            #2;
            if (fill_busy) busy_n++;
            if (fill_done) done_n++;
            if (a_ready || b_ready) rdy_n++;
            if (done_n > 0) post++;
            step();
        end
        a_valid = 0; b_valid = 0; fill_start = 0;
        chk("fill_busy_cycles", 32'(busy_n), 32'(512));
        chk("fill_done_pulses", 32'(done_n), 32'(1));
        chk("fill_ready_cycles", 32'(rdy_n), 32'(0));
        access(0, 0, 9'h000, 8'h00, gnt, rv, rd);
        chk("fill_rd_000", 32'(rd), 32'(8'hC3));
        access(1, 0, 9'h1FF, 8'h00, gnt, rv, rd);
        chk("fill_rd_1ff", 32'(rd), 32'(8'hC3));

        // Reset at fill cycle 100 aborts without fill_done
        fill_start = 1; fill_data = 8'h96;
        step();
        fill_start = 0;
        repeat (100) step();
        #2;
        chk("midfill_busy", 32'(fill_busy), 32'(1));
        reset = 1;
        step();
        reset = 0;
        #2;
        chk("abort_busy", 32'(fill_busy), 32'(0));
        done_n = 0; busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (fill_done) done_n++;
            if (fill_busy) busy_n++;
            step();
        end
        chk("abort_no_done", 32'(done_n), 32'(0));
        chk("abort_no_busy", 32'(busy_n), 32'(0));
        access(0, 1, 9'h005, 8'h11, gnt, rv, rd);
        chk("post_abort_grant", 32'(gnt), 32'(1));
        chk("post_abort_rsp", 32'(rv), 32'(1));
        access(1, 0, 9'h005, 8'h00, gnt, rv, rd);
        chk("post_abort_read", 32'(rd), 32'(8'h11));

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
